// File: rtl/booth_sequential_multiplier.sv
// Sequential signed radix-2 Booth multiplier, one Booth step per clock, start/busy/done handshake.
// Optional macro BOOTH_ZERO_SKIP_EN: a zero operand bypasses the Booth steps (latency 1).
module booth_sequential_multiplier #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   M,
    input  logic [N-1:0]   Q,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] Prod
);

    // state  | meaning
    // S_IDLE | waiting for start
    // S_RUN  | one Booth step per cycle, r_cnt steps remaining
    // S_DONE | Prod just written, done high for this cycle, start accepted
    // S_ZERO | zero operand seen, Prod cleared next cycle (zero-skip build only)
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ZERO = 2'd3
    } state_t;

    localparam int CW = $clog2(N + 1);

    state_t         r_state;
    logic [N-1:0]   r_mreg;
    logic [N:0]     r_a;
    logic [N-1:0]   r_qreg;
    logic           r_q1;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_prod;
    logic           r_busy;
    logic           r_done;

    logic [N:0]     w_m_ext;
    logic [N:0]     w_sum;
    logic [N:0]     w_a_next;
    logic [N-1:0]   w_q_next;
    logic           w_q1_next;
    logic           w_last_step;
`ifdef BOOTH_ZERO_SKIP_EN
    logic           w_zero_op;
    assign w_zero_op = (M == '0) || (Q == '0);
`endif

    // A is one bit wider than M so that subtracting -2^(N-1) cannot overflow.
    assign w_m_ext = {r_mreg[N-1], r_mreg};

    always_comb begin
        w_sum = r_a;
        case ({r_qreg[0], r_q1})
            2'b01:   w_sum = r_a + w_m_ext;
            2'b10:   w_sum = r_a - w_m_ext;
            default: w_sum = r_a;
        endcase
    end

    assign w_a_next    = {w_sum[N], w_sum[N:1]};
    assign w_q_next    = {w_sum[0], r_qreg[N-1:1]};
    assign w_q1_next   = r_qreg[0];
    assign w_last_step = (r_cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mreg  <= '0;
            r_a     <= '0;
            r_qreg  <= '0;
            r_q1    <= 1'b0;
            r_cnt   <= '0;
            r_prod  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_mreg <= M;
                        r_a    <= '0;
                        r_qreg <= Q;
                        r_q1   <= 1'b0;
                        r_cnt  <= CW'(N);
`ifdef BOOTH_ZERO_SKIP_EN
                        if (w_zero_op) begin
                            r_state <= S_ZERO;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end
`else
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a    <= w_a_next;
                    r_qreg <= w_q_next;
                    r_q1   <= w_q1_next;
                    r_cnt  <= r_cnt - CW'(1);
                    if (w_last_step) begin
                        r_prod  <= {w_a_next[N-1:0], w_q_next};
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_ZERO: begin
                    r_prod  <= '0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Prod = r_prod;

endmodule

// File: tb/tb_booth_sequential_multiplier.sv
// Self-checking bench for booth_sequential_multiplier (N=4) against a signed-multiply reference.
// Expectations for zero operands follow the BOOTH_ZERO_SKIP_EN build setting.
module tb_booth_sequential_multiplier;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] M;
    logic [N-1:0] Q;
    logic         busy;
    logic         done;
    logic [7:0]   Prod;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] last_exp = 8'h00;

    booth_sequential_multiplier #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .M     (M),
        .Q     (Q),
        .busy  (busy),
        .done  (done),
        .Prod  (Prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_prod(input logic [3:0] m, input logic [3:0] q);
        int pm, pq;
        pm = $signed(m);
        pq = $signed(q);
        return 8'(pm * pq);
    endfunction

    function automatic int ref_lat(input logic [3:0] m, input logic [3:0] q);
`ifdef BOOTH_ZERO_SKIP_EN
        if (m == 4'd0 || q == 4'd0) return 1;
`endif
        return N;
    endfunction

    function automatic int ref_busy(input logic [3:0] m, input logic [3:0] q);
`ifdef BOOTH_ZERO_SKIP_EN
        if (m == 4'd0 || q == 4'd0) return 0;
`endif
        return N;
    endfunction

    // Drives one operation from IDLE/DONE and measures the response.
    task automatic run_op(input logic [3:0] m, input logic [3:0] q, input logic [7:0] prev,
                          output logic [7:0] p, output int lat, output int bcnt,
                          output bit stable, output logic done_after);
        start = 1'b1;
        M = m;
        Q = q;
        @(posedge clk); #1;
        start = 1'b0;
        M = 4'($urandom);
        Q = 4'($urandom);
        lat = 0;
        bcnt = 0;
        stable = 1'b1;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) bcnt++;
            if (Prod !== prev) stable = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        p = Prod;
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic test_reset();
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++;
        if (Prod !== 8'h00) begin n_fail++; $display("FAIL reset_prod got %h want 00", Prod); end
    endtask

    task automatic test_directed();
        logic [3:0] tm [5] = '{4'h3, 4'h8, 4'h8, 4'h7, 4'h5};
        logic [3:0] tq [5] = '{4'hE, 4'h8, 4'h7, 4'h7, 4'hD};
        logic [7:0] tp [5] = '{8'hFA, 8'h40, 8'hC8, 8'h31, 8'hF1};
        logic [7:0] p;
        int lat, bcnt;
        bit stable;
        logic da;
        for (int i = 0; i < 5; i++) begin
            run_op(tm[i], tq[i], last_exp, p, lat, bcnt, stable, da);
            n_tests++;
            if (p !== tp[i]) begin n_fail++; $display("FAIL dir_prod[%0d] got %h want %h", i, p, tp[i]); end
            n_tests++;
            if (lat != 4) begin n_fail++; $display("FAIL dir_lat[%0d] got %0d want 4", i, lat); end
            n_tests++;
            if (bcnt != 4) begin n_fail++; $display("FAIL dir_busy[%0d] got %0d want 4", i, bcnt); end
            n_tests++;
            if (da !== 1'b0) begin n_fail++; $display("FAIL dir_done_pulse[%0d] got %b want 0", i, da); end
            last_exp = tp[i];
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] p, e;
        int lat, bcnt, gap;
        bit stable;
        logic da;
        for (int i = 0; i < 256; i++) begin
            logic [3:0] m, q;
            m = 4'(i >> 4);
            q = 4'(i);
            e = ref_prod(m, q);
            run_op(m, q, last_exp, p, lat, bcnt, stable, da);
            n_tests++;
            if (p !== e) begin n_fail++; $display("FAIL exh_prod m=%h q=%h got %h want %h", m, q, p, e); end
            n_tests++;
            if (lat != ref_lat(m, q)) begin n_fail++; $display("FAIL exh_lat m=%h q=%h got %0d want %0d", m, q, lat, ref_lat(m, q)); end
            n_tests++;
            if (bcnt != ref_busy(m, q)) begin n_fail++; $display("FAIL exh_busy m=%h q=%h got %0d want %0d", m, q, bcnt, ref_busy(m, q)); end
            n_tests++;
            if (!stable) begin n_fail++; $display("FAIL exh_stable m=%h q=%h prod moved before done, want %h", m, q, last_exp); end
            n_tests++;
            if (da !== 1'b0) begin n_fail++; $display("FAIL exh_done_pulse m=%h q=%h got %b want 0", m, q, da); end
            last_exp = e;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk); #1;
                n_tests++;
                if (Prod !== last_exp) begin n_fail++; $display("FAIL exh_idle_hold got %h want %h", Prod, last_exp); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        logic [7:0] p1, p2;
        logic b_run;
        start = 1'b1;
        M = 4'h5;
        Q = 4'hD;
        @(posedge clk); #1;
        M = 4'hF;
        Q = 4'hF;
        c1 = 0;
        while (done !== 1'b1 && c1 < 20) begin @(posedge clk); #1; c1++; end
        p1 = Prod;
        @(posedge clk); #1;
        start = 1'b0;
        M = 4'($urandom);
        Q = 4'($urandom);
        b_run = busy;
        c2 = 1;
        while (done !== 1'b1 && c2 < 20) begin @(posedge clk); #1; c2++; end
        p2 = Prod;
        n_tests++;
        if (c1 != 4) begin n_fail++; $display("FAIL b2b_first_lat got %0d want 4", c1); end
        n_tests++;
        if (p1 !== 8'hF1) begin n_fail++; $display("FAIL b2b_first_prod got %h want f1", p1); end
        n_tests++;
        if (b_run !== 1'b1) begin n_fail++; $display("FAIL b2b_rerun_busy got %b want 1", b_run); end
        n_tests++;
        if (c2 != 5) begin n_fail++; $display("FAIL b2b_gap got %0d want 5", c2); end
        n_tests++;
        if (p2 !== 8'h01) begin n_fail++; $display("FAIL b2b_second_prod got %h want 01", p2); end
        @(posedge clk); #1;
        last_exp = 8'h01;
    endtask

    task automatic test_reset_mid_run();
        bit seen_done;
        logic [7:0] p;
        int lat, bcnt;
        bit stable;
        logic da;
        start = 1'b1;
        M = 4'h7;
        Q = 4'h7;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", done); end
        n_tests++;
        if (Prod !== 8'h00) begin n_fail++; $display("FAIL midrst_prod got %h want 00", Prod); end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done = 1'b1;
        end
        n_tests++;
        if (seen_done) begin n_fail++; $display("FAIL midrst_no_done got 1 want 0"); end
        last_exp = 8'h00;
        run_op(4'h7, 4'h7, last_exp, p, lat, bcnt, stable, da);
        n_tests++;
        if (p !== 8'h31) begin n_fail++; $display("FAIL midrst_next_prod got %h want 31", p); end
        n_tests++;
        if (lat != 4) begin n_fail++; $display("FAIL midrst_next_lat got %0d want 4", lat); end
        last_exp = 8'h31;
    endtask

    task automatic test_zero();
        logic [3:0] zm [2] = '{4'h0, 4'h6};
        logic [3:0] zq [2] = '{4'h5, 4'h0};
        logic [7:0] p;
        int lat, bcnt;
        bit stable;
        logic da;
        for (int i = 0; i < 2; i++) begin
            run_op(4'h7, 4'h3, last_exp, p, lat, bcnt, stable, da);
            last_exp = 8'h15;
            run_op(zm[i], zq[i], last_exp, p, lat, bcnt, stable, da);
            n_tests++;
            if (p !== 8'h00) begin n_fail++; $display("FAIL zero_prod[%0d] got %h want 00", i, p); end
            n_tests++;
            if (lat != ref_lat(zm[i], zq[i])) begin n_fail++; $display("FAIL zero_lat[%0d] got %0d want %0d", i, lat, ref_lat(zm[i], zq[i])); end
            n_tests++;
            if (bcnt != ref_busy(zm[i], zq[i])) begin n_fail++; $display("FAIL zero_busy[%0d] got %0d want %0d", i, bcnt, ref_busy(zm[i], zq[i])); end
            n_tests++;
            if (!stable) begin n_fail++; $display("FAIL zero_stable[%0d] prod moved before done, want %h", i, last_exp); end
            last_exp = 8'h00;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        M = '0;
        Q = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_directed();
        test_back_to_back();
        test_reset_mid_run();
        test_zero();
        test_exhaustive();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
